axi_txn_sequencer: RTL
======================

// Module: axi_txn_sequencer
// PURPOSE
//  Sequences up to NUM_MASTERS AXI4-Lite master test engines that each expose an
//  INIT_AXI_TXN / TXN_DONE / ERROR handshake. One at a time and in ascending index
//  order, it starts every enabled master, waits for completion or timeout, records
//  per-master error status, and repeats for NUM_PASSES passes.
//  It sits between the PS/GPIO control path and the master IPs and replaces manual,
//  one-by-one test triggering.
// PARAMETERS
//  NUM_MASTERS     4      number of attached masters (1..16)
//  PASS_W          8      width of NUM_PASSES / PASS_CNT
//  TIMEOUT_CYCLES  4096   max ACLK cycles allowed in WAIT per transaction (>=4)
//  STOP_ON_ERROR   0      1: end the sequence after the first error or timeout
// PORTS
//  ACLK          in   1            clock
//  ARESET        in   1            synchronous, active-high reset
//  START         in   1            level; sampled only in IDLE
//  ENABLE_MASK   in   NUM_MASTERS  masters to run; latched on START
//  NUM_PASSES    in   PASS_W       passes to run; latched on START
//  INIT_AXI_TXN  out  NUM_MASTERS  one-hot, 1-cycle start pulse to a master
//  TXN_DONE      in   NUM_MASTERS  master completion level (stays high until next init)
//  TXN_ERROR     in   NUM_MASTERS  master error flag, valid with TXN_DONE
//  BUSY          out  1            sequence in progress
//  SEQ_DONE      out  1            1-cycle pulse when the sequence ends
//  SEQ_ERROR     out  1            |ERROR_MASK | |TIMEOUT_MASK; held until next START
//  ERROR_MASK    out  NUM_MASTERS  sticky: master reported ERROR
//  TIMEOUT_MASK  out  NUM_MASTERS  sticky: master timed out
//  PASS_CNT      out  PASS_W       completed passes
//  CUR_MASTER    out  $clog2(NUM_MASTERS)  index being serviced
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timer 0; done_q 0. Reset mid-sequence aborts at once:
//  INIT is low from the next cycle and no SEQ_DONE is issued.
//  All outputs are registered. done_q <= TXN_DONE every cycle. Completion event is
//  TXN_DONE[cur] & ~done_q[cur] (rising edge only), so a stale high level is ignored.
//  FSM states:
//   IDLE: START=1 -> latch mask and passes; clear ERROR_MASK, TIMEOUT_MASK, PASS_CNT, SEQ_ERROR;
//     BUSY=1; cur=lowest enabled; go to ISSUE. If mask==0 or passes==0, go to FINISH instead.
//   ISSUE (1 cycle): INIT_AXI_TXN[cur]=1 for exactly this cycle; timer=0 -> WAIT.
//   WAIT: timer++. On a completion event: ERROR_MASK[cur] |= TXN_ERROR[cur] -> ADVANCE.
//     If timer==TIMEOUT_CYCLES-1 with no event: TIMEOUT_MASK[cur]=1 -> ADVANCE.
//     If both occur in the same cycle, the completion event wins.
//   ADVANCE (1 cycle): if STOP_ON_ERROR and an error/timeout was recorded -> FINISH.
//     Else if an enabled index > cur exists: cur=next, go to ISSUE.
//     Else PASS_CNT++. If PASS_CNT+1==passes -> FINISH; else cur=lowest enabled, go to ISSUE.
//     PASS_CNT wraps at 2^PASS_W; there is no guard against wrap.
//  FINISH (1 cycle): SEQ_DONE=1, BUSY=0 -> IDLE.
//  Latency: START seen at edge k -> BUSY high after k; INIT high during cycle k+1..k+2.
//   Completion at edge d -> next INIT during cycle d+2..d+3.
//  START while BUSY is ignored. START held high re-triggers on the cycle after FINISH.
//  Disabled masters never receive INIT, and their TXN_DONE/TXN_ERROR inputs are ignored.
//  SEQ_ERROR updates in the same cycle as the mask bit that sets it.
// TESTING
//  1 mask=4'b0101, passes=2, masters DONE 20 cycles after INIT with no error
//    -> INIT order 0,2,0,2; one SEQ_DONE pulse; PASS_CNT=2; SEQ_ERROR=0.
//  2 mask=4'b1111, passes=1, master 1 returns ERROR=1
//    -> ERROR_MASK=4'b0010; SEQ_ERROR=1; masters 2 and 3 still run (STOP_ON_ERROR=0).
//  3 master 3 never raises DONE, TIMEOUT_CYCLES=64 -> TIMEOUT_MASK[3]=1 after 64 WAIT cycles;
//    sequence completes; SEQ_ERROR=1.
//  4 mask=0 or passes=0 -> SEQ_DONE 2 cycles after START; no INIT pulse; SEQ_ERROR=0.
//  5 TXN_DONE[0] already high from an earlier run -> no false completion; waits for a new rising edge.
//  6 ARESET asserted during WAIT -> INIT, BUSY, and masks are 0 next cycle; no SEQ_DONE;
//    a fresh START runs normally.

Source files
------------

// File: rtl/axi_txn_sequencer.sv
// axi_txn_sequencer: starts each enabled AXI4-Lite master test engine in turn,
// in ascending index order. It waits for a rising TXN_DONE or a timeout,
// records sticky error and timeout status per master, and repeats the whole
// round NUM_PASSES times. All outputs are registered.
module axi_txn_sequencer #(
   parameter int NUM_MASTERS    = 4,
   parameter int PASS_W         = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter bit STOP_ON_ERROR  = 1'b0,
   localparam int CUR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   START,
   input  logic [NUM_MASTERS-1:0] ENABLE_MASK,
   input  logic [PASS_W-1:0]      NUM_PASSES,
   output logic [NUM_MASTERS-1:0] INIT_AXI_TXN,
   input  logic [NUM_MASTERS-1:0] TXN_DONE,
   input  logic [NUM_MASTERS-1:0] TXN_ERROR,
   output logic                   BUSY,
   output logic                   SEQ_DONE,
   output logic                   SEQ_ERROR,
   output logic [NUM_MASTERS-1:0] ERROR_MASK,
   output logic [NUM_MASTERS-1:0] TIMEOUT_MASK,
   output logic [PASS_W-1:0]      PASS_CNT,
   output logic [CUR_W-1:0]       CUR_MASTER
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_ADVANCE = 3'd3;
   localparam logic [2:0] S_FINISH  = 3'd4;

   logic [2:0]             state_q,     state_d;
   logic [NUM_MASTERS-1:0] mask_q,      mask_d;
   logic [PASS_W-1:0]      passes_q,    passes_d;
   logic [PASS_W-1:0]      pass_cnt_q,  pass_cnt_d;
   logic [CUR_W-1:0]       cur_q,       cur_d;
   logic [TMR_W-1:0]       timer_q,     timer_d;
   logic [NUM_MASTERS-1:0] init_q,      init_d;
   logic [NUM_MASTERS-1:0] err_q,       err_d;
   logic [NUM_MASTERS-1:0] tmo_q,       tmo_d;
   logic                   busy_q,      busy_d;
   logic                   seq_done_q,  seq_done_d;
   logic                   seq_error_q, seq_error_d;
   logic [NUM_MASTERS-1:0] done_q;

   logic                   txn_event;
   logic [CUR_W:0]         next_hit;
   logic [PASS_W-1:0]      pass_inc;

   // Lowest set index of a mask (0 when the mask is empty).
   function automatic logic [CUR_W-1:0] lowest_idx(input logic [NUM_MASTERS-1:0] m);
      lowest_idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (m[i]) lowest_idx = CUR_W'(i);
      end
   endfunction

   // {found, index} of the lowest enabled master strictly above cur.
   function automatic logic [CUR_W:0] next_above(input logic [NUM_MASTERS-1:0] m,
                                                 input logic [CUR_W-1:0]       cur);
      next_above = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) next_above = {1'b1, CUR_W'(i)};
      end
   endfunction

   // Only a fresh rising edge of the serviced master's DONE counts; a level
   // left high from an earlier transaction is ignored.
   assign txn_event = TXN_DONE[cur_q] & ~done_q[cur_q];
   assign next_hit  = next_above(mask_q, cur_q);
   assign pass_inc  = pass_cnt_q + PASS_W'(1);

   // Next-state and next-output logic for the sequencing FSM.
   always_comb begin
      // NOTE: every _d starts from its held value, so no path can infer a latch.
      state_d    = state_q;
      mask_d     = mask_q;
      passes_d   = passes_q;
      pass_cnt_d = pass_cnt_q;
      cur_d      = cur_q;
      timer_d    = timer_q;
      err_d      = err_q;
      tmo_d      = tmo_q;
      busy_d     = busy_q;
      init_d     = '0;
      seq_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               mask_d     = ENABLE_MASK;
               passes_d   = NUM_PASSES;
               pass_cnt_d = '0;
               err_d      = '0;
               tmo_d      = '0;
               busy_d     = 1'b1;
               cur_d      = lowest_idx(ENABLE_MASK);
               if ((ENABLE_MASK == '0) || (NUM_PASSES == '0)) state_d = S_FINISH;
               else                                           state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            init_d  = NUM_MASTERS'(1) << cur_q;
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A completion on the last allowed cycle beats the timeout.
            if (txn_event) begin
               err_d[cur_q] = err_q[cur_q] | TXN_ERROR[cur_q];
               state_d      = S_ADVANCE;
            end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               tmo_d[cur_q] = 1'b1;
               state_d      = S_ADVANCE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_ADVANCE: begin
            if (STOP_ON_ERROR && seq_error_q) begin
               state_d = S_FINISH;
            end else if (next_hit[CUR_W]) begin
               cur_d   = next_hit[CUR_W-1:0];
               state_d = S_ISSUE;
            end else begin
               pass_cnt_d = pass_inc;
               if (pass_inc == passes_q) begin
                  state_d = S_FINISH;
               end else begin
                  cur_d   = lowest_idx(mask_q);
                  state_d = S_ISSUE;
               end
            end
         end
         S_FINISH: begin
            seq_done_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Derived from the next mask values so it moves together with them.
      seq_error_d = (|err_d) | (|tmo_d);
   end

   // State and output registers; reset aborts any sequence immediately.
   always_ff @(posedge ACLK) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (ARESET) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         passes_q    <= '0;
         pass_cnt_q  <= '0;
         cur_q       <= '0;
         timer_q     <= '0;
         init_q      <= '0;
         err_q       <= '0;
         tmo_q       <= '0;
         busy_q      <= 1'b0;
         seq_done_q  <= 1'b0;
         seq_error_q <= 1'b0;
         done_q      <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         passes_q    <= passes_d;
         pass_cnt_q  <= pass_cnt_d;
         cur_q       <= cur_d;
         timer_q     <= timer_d;
         init_q      <= init_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         busy_q      <= busy_d;
         seq_done_q  <= seq_done_d;
         seq_error_q <= seq_error_d;
         done_q      <= TXN_DONE;
      end
   end

   assign INIT_AXI_TXN = init_q;
   assign BUSY         = busy_q;
   assign SEQ_DONE     = seq_done_q;
   assign SEQ_ERROR    = seq_error_q;
   assign ERROR_MASK   = err_q;
   assign TIMEOUT_MASK = tmo_q;
   assign PASS_CNT     = pass_cnt_q;
   assign CUR_MASTER   = cur_q;

endmodule
